transmitter: RTL

TRANSMITTER -- requirements
Module: transmitter

---
 rtl/maple_pkg.sv | 42 ++++
 rtl/phase_timer.sv | 28 ++
 rtl/transmitter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/maple_pkg.sv
// Shared encodings for the two-wire transmitter: one-hot states, phase counts,
// START/END line tables and the DATA-phase line encoder.
package maple_pkg;

    typedef enum logic [6:0] {
        ST_IDLE  = 7'b000_0001,
        ST_START = 7'b000_0010,
        ST_LOAD  = 7'b000_0100,
        ST_DATA  = 7'b000_1000,
        ST_CRC   = 7'b001_0000,
        ST_END   = 7'b010_0000,
        ST_DONE  = 7'b100_0000
    } tx_state_t;

    localparam int START_PHASES = 10;
    localparam int END_PHASES   = 6;
    localparam int BIT_PHASES   = 2;

    localparam logic [3:0] START_LAST = 4'(START_PHASES - 1);
    localparam logic [3:0] END_LAST   = 4'(END_PHASES - 1);
    localparam logic [3:0] DATA_LAST  = 4'(8 * BIT_PHASES - 1);

    // Entries are {A,B}; index 0 is the first phase on the wire.
    localparam logic [START_PHASES-1:0][1:0] START_PATTERN = {
        2'b11, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01
    };
    localparam logic [END_PHASES-1:0][1:0] END_PATTERN = {
        2'b11, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10
    };

    function automatic logic [1:0] data_lines(input logic [7:0] data,
                                              input logic [2:0] bit_num,
                                              input logic       phase);
        logic b;
        b = data[3'd7 - bit_num];
        if (!bit_num[0]) begin
            return {~phase, b};
        end
        return {b, ~phase};
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Bus phase timer: down-counter reloaded to PHASE_CLKS-1, tick on terminal count.
module phase_timer #(
    parameter int PHASE_CLKS = 25
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PHASE_CLKS > 2) ? $clog2(PHASE_CLKS) : 1;

    logic [CW-1:0] count;

    assign tick = enable && !clear && (count == '0);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count <= '0;
        end else if (clear) begin
            count <= CW'(PHASE_CLKS - 1);
        end else if (enable) begin
            count <= tick ? CW'(PHASE_CLKS - 1) : count - CW'(1);
        end
    end

endmodule

// File: rtl/transmitter.sv
// Two-wire frame transmitter fed by AXI-Stream bytes (MSB first).
// Build option TX_CRC_EN appends an XOR check byte between the last byte and END.
module transmitter
    import maple_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 8,
    parameter int PHASE_CLKS           = 25
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESETN,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                            S_AXIS_TLAST,
    input  logic                            ENABLE,
    output logic                            SDCKA_O,
    output logic                            SDCKB_O,
    output logic                            SDCK_OE,
    output logic                            TRANSMITTING,
    output logic                            TX_UNDERRUN
);

    // state | meaning
    // IDLE  | bus released, accept first beat when ENABLE
    // START | 10-phase start pattern
    // DATA  | 8 bits, 2 phases each, clock role alternates A/B
    // LOAD  | one-cycle fetch of the next beat, lines held
    // CRC   | check byte in DATA encoding (TX_CRC_EN only)
    // END   | 6-phase end pattern
    // DONE  | one cycle with the bus released

    tx_state_t  state, state_next;
    logic [3:0] phase_cnt;
    logic [7:0] tx_byte;
    logic       tx_last;
    logic       tick;
    logic       tready;
    logic       underrun;
    logic       beat_accept;
    logic [1:0] lines;

`ifdef TX_CRC_EN
    logic [7:0] crc_acc;
`endif

    phase_timer #(
        .PHASE_CLKS(PHASE_CLKS)
    ) u_phase_timer (
        .aclk    (S_AXIS_ACLK),
        .aresetn (S_AXIS_ARESETN),
        .clear   (state == ST_IDLE),
        .enable  (state != ST_LOAD),
        .tick    (tick)
    );

    assign S_AXIS_TREADY = tready && S_AXIS_ARESETN;
    assign TX_UNDERRUN   = underrun && S_AXIS_ARESETN;
    assign beat_accept   = S_AXIS_TVALID && S_AXIS_TREADY;
    assign SDCKA_O       = lines[1];
    assign SDCKB_O       = lines[0];

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (beat_accept) state_next = ST_START;
            ST_START: if (tick && phase_cnt == START_LAST) state_next = ST_DATA;
            ST_DATA: begin
                if (tick && phase_cnt == DATA_LAST) begin
                    if (!tx_last) begin
                        state_next = ST_LOAD;
                    end else begin
`ifdef TX_CRC_EN
                        state_next = ST_CRC;
`else
                        state_next = ST_END;
`endif
                    end
                end
            end
            ST_LOAD:  state_next = S_AXIS_TVALID ? ST_DATA : ST_END;
`ifdef TX_CRC_EN
            ST_CRC:   if (tick && phase_cnt == DATA_LAST) state_next = ST_END;
`endif
            ST_END:   if (tick && phase_cnt == END_LAST) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        lines        = 2'b11;
        SDCK_OE      = 1'b0;
        TRANSMITTING = 1'b0;
        tready       = 1'b0;
        underrun     = 1'b0;
        case (state)
            ST_IDLE: tready = ENABLE;
            ST_START: begin
                lines        = START_PATTERN[phase_cnt];
                SDCK_OE      = 1'b1;
                TRANSMITTING = 1'b1;
            end
            ST_DATA: begin
                lines        = data_lines(tx_byte, phase_cnt[3:1], phase_cnt[0]);
                SDCK_OE      = 1'b1;
                TRANSMITTING = 1'b1;
            end
            // Holding the final phase of bit 0 stretches it by this one cycle.
            ST_LOAD: begin
                lines        = data_lines(tx_byte, 3'd7, 1'b1);
                SDCK_OE      = 1'b1;
                TRANSMITTING = 1'b1;
                tready       = 1'b1;
                underrun     = !S_AXIS_TVALID;
            end
`ifdef TX_CRC_EN
            ST_CRC: begin
                lines        = data_lines(crc_acc, phase_cnt[3:1], phase_cnt[0]);
                SDCK_OE      = 1'b1;
                TRANSMITTING = 1'b1;
            end
`endif
            ST_END: begin
                lines        = END_PATTERN[phase_cnt[2:0]];
                SDCK_OE      = 1'b1;
                TRANSMITTING = 1'b1;
            end
            ST_DONE: TRANSMITTING = 1'b1;
            default: lines = 2'b11;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            phase_cnt <= '0;
            tx_byte   <= '0;
            tx_last   <= 1'b0;
        end else begin
            if (beat_accept) begin
                tx_byte <= S_AXIS_TDATA;
                tx_last <= S_AXIS_TLAST;
            end
            if (state == ST_IDLE || state == ST_LOAD) begin
                phase_cnt <= '0;
            end else if (tick) begin
                phase_cnt <= (state_next != state) ? 4'd0 : phase_cnt + 4'd1;
            end
        end
    end

`ifdef TX_CRC_EN
    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            crc_acc <= '0;
        end else if (beat_accept) begin
            crc_acc <= (state == ST_IDLE) ? S_AXIS_TDATA : (crc_acc ^ S_AXIS_TDATA);
        end
    end
`endif

endmodule
